// File: rtl/ysyx_24080006_axi_arb.sv
// ysyx_24080006_axi_arb: single-outstanding arbiter that shares one downstream
// AXI port between the IFU read master and the LSU read/write masters.
// Optional feature: define ARB_RR_EN for round-robin IFU/LSU selection in IDLE
// (LSU write still precedes LSU read); otherwise fixed priority LSU-W > LSU-R > IFU.

package ysyx_24080006_axi_pkg;
   typedef struct packed {
      logic        arvalid;
      logic [3:0]  arid;
      logic [31:0] araddr;
      logic [7:0]  arlen;
      logic [2:0]  arsize;
      logic [1:0]  arburst;
      logic        rready;
   } axi_r_m2s_t;

   typedef struct packed {
      logic        arready;
      logic        rvalid;
      logic [3:0]  rid;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic        rlast;
   } axi_r_s2m_t;

   typedef struct packed {
      logic        awvalid;
      logic [3:0]  awid;
      logic [31:0] awaddr;
      logic [7:0]  awlen;
      logic [2:0]  awsize;
      logic [1:0]  awburst;
      logic        wvalid;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        wlast;
      logic        bready;
   } axi_w_m2s_t;

   typedef struct packed {
      logic        awready;
      logic        wready;
      logic        bvalid;
      logic [3:0]  bid;
      logic [1:0]  bresp;
   } axi_w_s2m_t;
endpackage

module ysyx_24080006_axi_arb
   import ysyx_24080006_axi_pkg::*;
#(
   parameter int unsigned BEAT_W = 8
) (
   input  logic       clock,
   input  logic       rst_n,
   input  axi_r_m2s_t ifu_r_m2s,
   output axi_r_s2m_t ifu_r_s2m,
   input  axi_r_m2s_t lsu_r_m2s,
   output axi_r_s2m_t lsu_r_s2m,
   input  axi_w_m2s_t lsu_w_m2s,
   output axi_w_s2m_t lsu_w_s2m,
   output axi_r_m2s_t mem_r_m2s,
   input  axi_r_s2m_t mem_r_s2m,
   output axi_w_m2s_t mem_w_m2s,
   input  axi_w_s2m_t mem_w_s2m,
   output logic [1:0] grant,
   output logic       burst_err
);

   typedef enum logic [1:0] {
      IDLE,
      R_IFU,
      R_LSU,
      W_LSU
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              armed;      // low for the first cycle after reset release
   logic [BEAT_W-1:0] beat_cnt;
   logic              ar_hs;
   logic              r_hs;

   assign ar_hs = mem_r_m2s.arvalid && mem_r_s2m.arready;
   assign r_hs  = mem_r_m2s.rready  && mem_r_s2m.rvalid;

   // State register; armed delays the first grant to the second edge after reset
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         armed <= 1'b0;
      end else begin
         state <= state_nxt;
         armed <= 1'b1;
      end
   end

`ifdef ARB_RR_EN
   logic last_lsu;

   // Remember which agent won the most recent grant (resets to LSU so IFU wins first tie)
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         last_lsu <= 1'b1;
      end else if (state == IDLE && state_nxt != IDLE) begin
         last_lsu <= (state_nxt != R_IFU);
      end
   end
`endif

   // Owner selection and combinational routing of the owner's channels
   always_comb begin
      state_nxt = state;
      grant     = 2'b00;
      ifu_r_s2m = '0;
      lsu_r_s2m = '0;
      lsu_w_s2m = '0;
      mem_r_m2s = '0;
      mem_w_m2s = '0;
      case (state)
         IDLE: begin
            if (armed) begin
`ifdef ARB_RR_EN
               if ((lsu_w_m2s.awvalid || lsu_r_m2s.arvalid) && !(ifu_r_m2s.arvalid && last_lsu))
                  state_nxt = lsu_w_m2s.awvalid ? W_LSU : R_LSU;
               else if (ifu_r_m2s.arvalid)
                  state_nxt = R_IFU;
`else
               if (lsu_w_m2s.awvalid)
                  state_nxt = W_LSU;
               else if (lsu_r_m2s.arvalid)
                  state_nxt = R_LSU;
               else if (ifu_r_m2s.arvalid)
                  state_nxt = R_IFU;
`endif
            end
         end
         R_IFU: begin
            grant     = 2'b01;
            mem_r_m2s = ifu_r_m2s;
            ifu_r_s2m = mem_r_s2m;
            if (mem_r_s2m.rvalid && ifu_r_m2s.rready && mem_r_s2m.rlast)
               state_nxt = IDLE;
         end
         R_LSU: begin
            grant     = 2'b10;
            mem_r_m2s = lsu_r_m2s;
            lsu_r_s2m = mem_r_s2m;
            if (mem_r_s2m.rvalid && lsu_r_m2s.rready && mem_r_s2m.rlast)
               state_nxt = IDLE;
         end
         W_LSU: begin
            grant     = 2'b10;
            mem_w_m2s = lsu_w_m2s;
            lsu_w_s2m = mem_w_s2m;
            if (mem_w_s2m.bvalid && lsu_w_m2s.bready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Beat counter tracks remaining beats; rlast disagreeing with it latches burst_err
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt  <= '0;
         burst_err <= 1'b0;
      end else if (ar_hs) begin
         beat_cnt <= BEAT_W'(mem_r_m2s.arlen);
      end else if (r_hs) begin
         if ((mem_r_s2m.rlast && beat_cnt != '0) || (!mem_r_s2m.rlast && beat_cnt == '0))
            burst_err <= 1'b1;
         if (beat_cnt != '0)
            beat_cnt <= beat_cnt - BEAT_W'(1);
      end
   end

endmodule

// File: tb/tb_ysyx_24080006_axi_arb.sv
// Testbench for ysyx_24080006_axi_arb. The bench acts as all three masters and
// as the downstream memory; the arbitration order is predicted from the
// selection rules over the set of pending requests. Honours ARB_RR_EN.

module tb_ysyx_24080006_axi_arb;
   import ysyx_24080006_axi_pkg::*;

   logic       clock = 1'b0;
   logic       rst_n;
   axi_r_m2s_t ifu_r_m2s, lsu_r_m2s, mem_r_m2s;
   axi_r_s2m_t ifu_r_s2m, lsu_r_s2m, mem_r_s2m;
   axi_w_m2s_t lsu_w_m2s, mem_w_m2s;
   axi_w_s2m_t lsu_w_s2m, mem_w_s2m;
   logic [1:0] grant;
   logic       burst_err;

   int          checks = 0;
   int          errors = 0;
   bit          last_lsu;     // model: last grant went to LSU
   bit          err_exp;      // model: sticky burst error
   bit          pend[3];      // 0 IFU read, 1 LSU read, 2 LSU write
   logic [31:0] req_addr[3];
   int unsigned req_len[3];

   always #5 clock = ~clock;

   ysyx_24080006_axi_arb #(.BEAT_W(8)) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .ifu_r_m2s (ifu_r_m2s),
      .ifu_r_s2m (ifu_r_s2m),
      .lsu_r_m2s (lsu_r_m2s),
      .lsu_r_s2m (lsu_r_s2m),
      .lsu_w_m2s (lsu_w_m2s),
      .lsu_w_s2m (lsu_w_s2m),
      .mem_r_m2s (mem_r_m2s),
      .mem_r_s2m (mem_r_s2m),
      .mem_w_m2s (mem_w_m2s),
      .mem_w_s2m (mem_w_s2m),
      .grant     (grant),
      .burst_err (burst_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic axi_r_s2m_t own_r(input int unsigned who);
      return (who == 0) ? ifu_r_s2m : lsu_r_s2m;
   endfunction

   function automatic axi_r_s2m_t other_r(input int unsigned who);
      return (who == 0) ? lsu_r_s2m : ifu_r_s2m;
   endfunction

   // Selection rule applied to the pending set
   function automatic int unsigned pick();
      bit          lsu_any  = pend[1] || pend[2];
      int unsigned lsu_pick = pend[2] ? 2 : 1;
`ifdef ARB_RR_EN
      if (lsu_any && pend[0]) return last_lsu ? 0 : lsu_pick;
`endif
      if (lsu_any) return lsu_pick;
      return 0;
   endfunction

   task automatic clear_inputs();
      ifu_r_m2s = '0;  ifu_r_m2s.rready = 1'b1;
      lsu_r_m2s = '0;  lsu_r_m2s.rready = 1'b1;
      lsu_w_m2s = '0;  lsu_w_m2s.bready = 1'b1;
      mem_r_s2m = '0;
      mem_w_s2m = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      for (int unsigned i = 0; i < 3; i++) pend[i] = 1'b0;
      last_lsu = 1'b1;
      err_exp  = 1'b0;
      repeat (2) @(posedge clock);
      #1 rst_n = 1'b1;
   endtask

   task automatic raise(input int unsigned who, input int unsigned len);
      pend[who]     = 1'b1;
      req_addr[who] = $urandom;
      req_len[who]  = len;
      case (who)
         0: begin
            ifu_r_m2s.arvalid = 1'b1; ifu_r_m2s.araddr = req_addr[0];
            ifu_r_m2s.arlen = len[7:0]; ifu_r_m2s.arid = 4'h1;
         end
         1: begin
            lsu_r_m2s.arvalid = 1'b1; lsu_r_m2s.araddr = req_addr[1];
            lsu_r_m2s.arlen = len[7:0]; lsu_r_m2s.arid = 4'h2;
         end
         default: begin
            lsu_w_m2s.awvalid = 1'b1; lsu_w_m2s.awaddr = req_addr[2];
            lsu_w_m2s.awid = 4'h3;
         end
      endcase
   endtask

   // Wait for the grant, then act as memory for the transaction of 'who'.
   task automatic serve(input int unsigned who, input bit early, input int unsigned ad,
                        input int unsigned wd, input int unsigned bd,
                        input int unsigned gap, input int abort);
      int unsigned n = 0;
      int unsigned nb;
      logic [31:0] data;
      logic [1:0]  resp;
      @(negedge clock);
      while (grant === 2'b00 && n < 20) begin
         if (n == 0) begin
            chk("idle_mem_arvalid", mem_r_m2s.arvalid, 1'b0);
            chk("idle_mem_rready", mem_r_m2s.rready, 1'b0);
            chk("idle_mem_awvalid", mem_w_m2s.awvalid, 1'b0);
            chk("idle_up_arready", {ifu_r_s2m.arready, lsu_r_s2m.arready, lsu_w_s2m.awready}, 3'b000);
         end
         n++;
         @(negedge clock);
      end
      chk("idle_gap", n, gap);
      if (n >= 20) return;
      chk("grant", grant, (who == 0) ? 2'b01 : 2'b10);
      pend[who] = 1'b0;
      last_lsu  = (who != 0);

      if (who == 2) begin
         chk("aw_pass_valid", mem_w_m2s.awvalid, 1'b1);
         chk("aw_pass_addr", mem_w_m2s.awaddr, req_addr[2]);
         chk("w_ifu_stall", ifu_r_s2m.arready, 1'b0);
         @(posedge clock); #1 mem_w_s2m.awready = 1'b1;
         @(negedge clock);
         chk("aw_ready_pass", lsu_w_s2m.awready, 1'b1);
         @(posedge clock); #1 mem_w_s2m.awready = 1'b0; lsu_w_m2s.awvalid = 1'b0;
         repeat (wd) begin
            @(negedge clock); chk("w_hold_grant", grant, 2'b10);
            @(posedge clock); #1;
         end
         data = $urandom;
         lsu_w_m2s.wvalid = 1'b1; lsu_w_m2s.wdata = data;
         lsu_w_m2s.wlast = 1'b1;  lsu_w_m2s.wstrb = 4'hf;
         mem_w_s2m.wready = 1'b1;
         @(negedge clock);
         chk("w_pass_valid", mem_w_m2s.wvalid, 1'b1);
         chk("w_pass_data", mem_w_m2s.wdata, data);
         chk("w_ready_pass", lsu_w_s2m.wready, 1'b1);
         @(posedge clock); #1 lsu_w_m2s.wvalid = 1'b0; mem_w_s2m.wready = 1'b0;
         repeat (bd) begin
            @(negedge clock); chk("b_hold_grant", grant, 2'b10);
            @(posedge clock); #1;
         end
         resp = 2'($urandom_range(0, 3));
         mem_w_s2m.bvalid = 1'b1; mem_w_s2m.bresp = resp;
         @(negedge clock);
         chk("b_pass_valid", lsu_w_s2m.bvalid, 1'b1);
         chk("b_pass_resp", lsu_w_s2m.bresp, resp);
         chk("b_bready_pass", mem_w_m2s.bready, 1'b1);
         @(posedge clock); #1 mem_w_s2m = '0;
      end else begin
         chk("ar_pass_valid", mem_r_m2s.arvalid, 1'b1);
         chk("ar_pass_addr", mem_r_m2s.araddr, req_addr[who]);
         chk("ar_pass_len", mem_r_m2s.arlen, req_len[who]);
         repeat (ad) begin
            @(posedge clock); #1;
            @(negedge clock); chk("ar_stall", own_r(who).arready, 1'b0);
         end
         @(posedge clock); #1 mem_r_s2m.arready = 1'b1;
         @(negedge clock);
         chk("ar_ready_pass", own_r(who).arready, 1'b1);
         chk("nonowner_arready", other_r(who).arready, 1'b0);
         @(posedge clock); #1 mem_r_s2m.arready = 1'b0;
         if (who == 0) ifu_r_m2s.arvalid = 1'b0; else lsu_r_m2s.arvalid = 1'b0;
         nb = early ? 1 : req_len[who] + 1;
         for (int b = 0; b < int'(nb); b++) begin
            if ($urandom_range(0, 1) == 1) begin
               @(negedge clock); chk("r_gap_rvalid", own_r(who).rvalid, 1'b0);
               @(posedge clock); #1;
            end
            data = $urandom;
            mem_r_s2m.rvalid = 1'b1; mem_r_s2m.rdata = data;
            mem_r_s2m.rlast  = (b == int'(nb) - 1);
            if (b == abort) begin
               #1 rst_n = 1'b0;
               #1;
               chk("rst_grant", grant, 2'b00);
               chk("rst_up_rvalid", own_r(who).rvalid, 1'b0);
               chk("rst_mem_rready", mem_r_m2s.rready, 1'b0);
               chk("rst_burst_err", burst_err, 1'b0);
               return;
            end
            @(negedge clock);
            chk("r_pass_valid", own_r(who).rvalid, 1'b1);
            chk("r_pass_data", own_r(who).rdata, data);
            chk("r_pass_last", own_r(who).rlast, (b == int'(nb) - 1));
            chk("nonowner_rvalid", other_r(who).rvalid, 1'b0);
            chk("r_grant", grant, (who == 0) ? 2'b01 : 2'b10);
            @(posedge clock); #1 mem_r_s2m = '0;
         end
         if (nb != req_len[who] + 1) err_exp = 1'b1;
         chk("burst_err", burst_err, err_exp);
      end
   endtask

   // Serve every pending request in model order
   task automatic run_all(input int unsigned first_gap, input bit rnd);
      int unsigned gap = first_gap;
      int unsigned who;
      while (pend[0] || pend[1] || pend[2]) begin
         who = pick();
         if (rnd)
            serve(who, 1'b0, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3), gap, -1);
         else
            serve(who, 1'b0, 0, 2, 3, gap, -1);
         gap = 1;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned mask;
      do_reset();
      // Simultaneous IFU/LSU reads, twice; first grant not before second edge
      raise(0, 1); raise(1, 0); run_all(2, 1'b0);
      raise(0, 1); raise(1, 0); run_all(1, 1'b0);
      // Single IFU burst of four beats
      raise(0, 3); run_all(1, 1'b0);
      // LSU write and read together: write held until B, then read
      raise(2, 0); raise(1, 2); run_all(1, 1'b0);
      // Random request mixes
      repeat (20) begin
         mask = $urandom_range(1, 7);
         for (int unsigned i = 0; i < 3; i++)
            if (mask[i]) raise(i, $urandom_range(0, 3));
         run_all(1, 1'b1);
      end
      // Early rlast: sticky burst error
      raise(1, 1); serve(1, 1'b1, 0, 0, 0, 1, -1);
      raise(0, 2); run_all(1, 1'b1);
      // Reset during beat 2 of an IFU burst, then recover
      raise(0, 3); serve(0, 1'b0, 0, 0, 0, 1, 2);
      do_reset();
      raise(0, 3); run_all(2, 1'b1);
      @(negedge clock);
      chk("final_idle_grant", grant, 2'b00);
      chk("final_burst_err", burst_err, err_exp);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
